// File: rtl/lsu_pkg.sv
// Shared constants for the memory-stage load/store unit: funct3 access codes,
// FSM state encoding and the alignment rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // funct3[1:0] carries the access size; the unsigned variants share it.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load extract: picks the byte/halfword at the byte offset and
// sign- or zero-extends it; zero latency, no flow control.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ext_data = {24'b0, byte_sel};
      F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ext_data = {16'b0, half_sel};
      default: ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: 2 cycles start-to-done plus one per mem_ready wait cycle;
// holds stall for the whole transaction and waits indefinitely on mem_ready.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              misalign
);

  logic [1:0]  state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        start;
  logic        aligned;
  logic        go;
  logic [3:0]  strb_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] ext_data;

  assign start   = valid_in & (mem_read | mem_write);
  assign aligned = is_aligned(funct3, addr[1:0]);
  assign go      = (state == ST_IDLE) & start & aligned;

  // Store lane steering; a load never drives byte enables.
  always_comb begin
    strb_nxt  = 4'b1111;
    wdata_nxt = wdata_in;
    case (funct3[1:0])
      2'b00: begin
        strb_nxt  = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        strb_nxt  = 4'b0011 << addr[1:0];
        wdata_nxt = {2{wdata_in[15:0]}};
      end
      default: ;
    endcase
    if (!mem_write) strb_nxt = 4'b0000;
  end

  load_extend u_load_extend (
    .mem_rdata (mem_rdata),
    .funct3    (f3_q),
    .addr_lo   (off_q),
    .ext_data  (ext_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      rdata     <= 32'b0;
      misalign  <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          misalign <= start & ~aligned;
          if (go) begin
            state     <= ST_REQ;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_we    <= mem_write;
            mem_wstrb <= strb_nxt;
            mem_wdata <= wdata_nxt;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            state <= ST_DONE;
            if (!mem_we) rdata <= ext_data;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded straight from state so a reset drops the request without a clock edge.
  assign mem_req = (state == ST_REQ);
  assign done    = (state == ST_DONE);
  assign stall   = go | mem_req;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level expectation model
// and a per-cycle compare process on the falling clock edge.
module tb_mem_access_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rstn;
  logic              valid_in, mem_read, mem_write;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata_in;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [31:0]       rdata;
  logic              done, stall, misalign;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata_in(wdata_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rdata(rdata), .done(done), .stall(stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          chk_en = 1'b0;
  logic        exp_req, exp_done, exp_stall, exp_misal, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_strb;
  logic [31:0] model_rdata;
  int          cyc, done_cyc, stall_cnt, req_cnt, misal_cnt;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_strb;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: spec arithmetic, independent of RTL structure
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 1;
      F3_H, F3_HU: return 2;
      default:     return 4;
    endcase
  endfunction

  function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % nbytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] m;
    if (nbytes(f3) == 4) return 4'hF;
    m = (32'd1 << nbytes(f3)) - 32'd1;
    m = m << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (nbytes(f3))
      1:       return {24'b0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'b0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] f3,
                                         input logic [31:0] a);
    logic [31:0] v, mask;
    int n;
    n = nbytes(f3);
    if (n == 4) return word;
    v    = word >> (8 * (a % 4));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if ((f3 == F3_B || f3 == F3_H) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check32("mem_req",  32'(mem_req),  32'(exp_req));
      check32("done",     32'(done),     32'(exp_done));
      check32("stall",    32'(stall),    32'(exp_stall));
      check32("misalign", 32'(misalign), 32'(exp_misal));
      check32("rdata",    rdata,         model_rdata);
      if (exp_req) begin
        check32("mem_addr",  mem_addr,         exp_addr);
        check32("mem_we",    32'(mem_we),      32'(exp_we));
        check32("mem_wstrb", 32'(mem_wstrb),   32'(exp_strb));
        if (exp_we) check32("mem_wdata", mem_wdata, exp_wdata);
      end
      if (done)     done_cyc = cyc;
      if (stall)    stall_cnt++;
      if (mem_req)  req_cnt++;
      if (misalign) misal_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle_exp();
    exp_req = 1'b0; exp_done = 1'b0; exp_stall = 1'b0; exp_misal = 1'b0;
  endtask

  // One access; starts and ends in an IDLE cycle just after a rising edge.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] word, input int wt);
    bit al;
    al = m_aligned(f3, a);
    cyc = 0; done_cyc = -1; stall_cnt = 0; req_cnt = 0; misal_cnt = 0;
    valid_in = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata_in = wd;
    mem_ready = 1'b0; mem_rdata = $urandom;
    set_idle_exp();
    exp_stall = al;
    exp_addr  = {a[31:2], 2'b00};
    exp_we    = wr;
    exp_strb  = wr ? m_strb(f3, a) : 4'b0000;
    exp_wdata = m_wdata(f3, wd);
    tick();
    // Scrambled inputs after the start must be ignored.
    valid_in = 1'b0; addr = $urandom; wdata_in = $urandom; funct3 = 3'($urandom);
    mem_read = 1'($urandom); mem_write = 1'($urandom);
    if (!al) begin
      exp_misal = 1'b1; exp_stall = 1'b0;
      tick();
      exp_misal = 1'b0;
    end else begin
      for (int i = 0; i <= wt; i++) begin
        if (i == 0) begin
          obs_addr = mem_addr; obs_strb = mem_wstrb; obs_wdata = mem_wdata;
        end
        exp_req = 1'b1; exp_stall = 1'b1;
        mem_ready = (i == wt);
        mem_rdata = (i == wt) ? word : $urandom;
        tick();
      end
      exp_req = 1'b0; exp_stall = 1'b0; exp_done = 1'b1;
      mem_ready = 1'b1; mem_rdata = $urandom;
      if (!wr) model_rdata = m_load(word, f3, a);
      tick();
      exp_done = 1'b0; mem_ready = 1'b0;
    end
  endtask

  initial begin
    rstn = 1'b0; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = '0; wdata_in = 32'b0; mem_ready = 1'b0; mem_rdata = 32'b0;
    model_rdata = 32'b0; cyc = 0;
    set_idle_exp();
    exp_we = 1'b0; exp_addr = 32'b0; exp_strb = 4'b0; exp_wdata = 32'b0;
    #2;
    check32("rst_mem_req",   32'(mem_req),   32'd0);
    check32("rst_mem_addr",  mem_addr,       32'd0);
    check32("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check32("rst_mem_wdata", mem_wdata,      32'd0);
    check32("rst_rdata",     rdata,          32'd0);
    check32("rst_done_stall_misal", {29'b0, mem_we, done, misalign}, 32'd0);
    @(negedge clk); #1 rstn = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();

    access(1, 0, F3_W, 32'h1000, 32'h0, 32'hDEADBEEF, 0);
    check32("lw_rdata", rdata, 32'hDEADBEEF);
    check32("lw_done_cyc", 32'(done_cyc), 32'd2);
    check32("lw_stall_cycles", 32'(stall_cnt), 32'd2);

    access(1, 0, F3_B, 32'h1003, 32'h0, 32'h80FF7F01, 1);
    check32("lb_rdata", rdata, 32'hFFFFFF80);
    access(1, 0, F3_BU, 32'h1003, 32'h0, 32'h80FF7F01, 0);
    check32("lbu_rdata", rdata, 32'h00000080);

    access(0, 1, F3_H, 32'h2002, 32'h1234ABCD, 32'h0, 3);
    check32("sh_addr", obs_addr, 32'h2000);
    check32("sh_wstrb", 32'(obs_strb), 32'hC);
    check32("sh_wdata", obs_wdata, 32'hABCDABCD);
    check32("sh_done_cyc", 32'(done_cyc), 32'd5);
    check32("sh_rdata_kept", rdata, 32'h00000080);

    access(1, 0, F3_H, 32'h1002, 32'h0, 32'h80011234, 0);
    check32("lh_hi_rdata", rdata, 32'hFFFF8001);
    access(1, 0, F3_HU, 32'h1002, 32'h0, 32'h80011234, 2);
    check32("lhu_rdata", rdata, 32'h00008001);
    access(1, 0, F3_H, 32'h1000, 32'h0, 32'h1234F00D, 0);
    check32("lh_lo_rdata", rdata, 32'hFFFFF00D);
    access(1, 0, F3_B, 32'h1002, 32'h0, 32'h00AB0000, 0);
    check32("lb_off2_rdata", rdata, 32'hFFFFFFAB);

    access(0, 1, F3_W, 32'h3004, 32'hCAFEF00D, 32'h0, 1);
    check32("sw_wstrb", 32'(obs_strb), 32'hF);
    check32("sw_wdata", obs_wdata, 32'hCAFEF00D);

    access(1, 0, F3_W, 32'h1002, 32'h0, 32'h11111111, 0);
    check32("mis_lw_pulses", 32'(misal_cnt), 32'd1);
    check32("mis_lw_req", 32'(req_cnt), 32'd0);
    check32("mis_lw_stall", 32'(stall_cnt), 32'd0);
    check32("mis_lw_done", 32'(done_cyc), 32'hFFFFFFFF);
    access(1, 0, F3_H, 32'h1001, 32'h0, 32'h22222222, 0);
    check32("mis_lh_pulses", 32'(misal_cnt), 32'd1);
    check32("mis_lh_req", 32'(req_cnt), 32'd0);

    access(1, 1, F3_B, 32'h5001, 32'h00000077, 32'h33333333, 0);
    check32("rw_store_wstrb", 32'(obs_strb), 32'h2);
    check32("rw_store_wdata", obs_wdata, 32'h77777777);
    check32("rw_rdata_kept", rdata, 32'hFFFFFFAB);

    // Reset in the middle of a waiting request.
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; addr = 32'h1000;
    exp_stall = 1'b1; exp_addr = 32'h1000; exp_we = 1'b0; exp_strb = 4'b0;
    tick();
    valid_in = 1'b0; mem_ready = 1'b0;
    chk_en = 1'b0;
    check32("rst_mid_req_before", 32'(mem_req), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check32("rst_mid_req_drop", 32'(mem_req), 32'd0);
    check32("rst_mid_stall", 32'(stall), 32'd0);
    check32("rst_mid_rdata", rdata, 32'd0);
    check32("rst_mid_addr", mem_addr, 32'd0);
    model_rdata = 32'b0;
    @(negedge clk); #1 rstn = 1'b1;
    tick();
    set_idle_exp();
    chk_en = 1'b1;
    tick();
    access(0, 1, F3_B, 32'h0, 32'h000000A5, 32'h0, 0);
    check32("post_rst_sb_wstrb", 32'(obs_strb), 32'h1);
    check32("post_rst_sb_wdata", obs_wdata, 32'hA5A5A5A5);
    check32("post_rst_sb_done", 32'(done_cyc), 32'd2);
    check32("post_rst_rdata", rdata, 32'd0);

    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the five-stage RISC-V core. It takes one load or store per request from the EX/MEM latch and runs it over a request/ready handshake to word-organised data memory. For loads it aligns and sign- or zero-extends the returned word into `rdata`, which the writeback mux selects when mem-to-reg is set. It stalls the pipeline for the whole transaction.

## Interface
- `ADDR_W`, 32, byte-address width.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `valid_in` in 1: EX/MEM latch holds a live instruction.
- `mem_read` in 1: instruction is a load.
- `mem_write` in 1: instruction is a store.
- `funct3` in 3: access size and sign. Values: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `addr` in ADDR_W: byte address (ALU result).
- `wdata_in` in 32: store data (rs2), right-aligned.
- `mem_req` out 1: request to data memory.
- `mem_we` out 1: request is a write.
- `mem_addr` out ADDR_W: word address, bits [1:0] = 0.
- `mem_wstrb` out 4: byte enables.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_ready` in 1: memory accepts or completes the request this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ready` is high on a read.
- `rdata` out 32: extended load result toward WB.
- `done` out 1: one-cycle pulse when the access completes.
- `stall` out 1: freeze IF/ID/EX and the EX/MEM latch.
- `misalign` out 1: one-cycle pulse when an access is rejected.

## Operation
- States:
  - IDLE: no access outstanding.
  - REQ: request registered; `mem_req` high until `mem_ready` is sampled high.
  - DONE: one cycle; `done` high.
- Start condition is `valid_in & (mem_read | mem_write)`.
  - If `mem_read` and `mem_write` are both high, the access is treated as a store.
- Alignment rules:
  - Halfword needs `addr[0]=0`.
  - Word needs `addr[1:0]=0`.
  - A misaligned start produces no memory request. `misalign` pulses the next cycle and the state stays IDLE.
- In IDLE, a valid start registers these in the same edge and moves to REQ:
  - `mem_addr = {addr[ADDR_W-1:2],2'b00}`
  - `mem_we`
  - `mem_wstrb`
  - `mem_wdata`
- Store lane mapping:
  - b: strobe `4'b0001 << addr[1:0]`; data is `{4{wdata_in[7:0]}}`.
  - h: strobe `4'b0011 << addr[1:0]`; data is `{2{wdata_in[15:0]}}`.
  - w: strobe `4'b1111`; data is `wdata_in`.
- Loads use `mem_wstrb=0`.
- Load extract:
  - Select the byte or halfword at offset `addr[1:0]`.
  - b/h sign-extend; bu/hu zero-extend; w passes through.
  - The result is registered into `rdata` on the `mem_ready` edge.
- `rdata` holds its value until the next load completes. Stores leave `rdata` unchanged.
- `stall` is combinational: `(IDLE & valid start & aligned) | REQ`. It is low in DONE, so the pipeline advances in the same cycle `done` is high.

## Timing
- Reset values: state IDLE, all outputs 0 (`rdata`, `mem_addr`, `mem_wdata`, `mem_wstrb` included).
- Minimum latency: start at edge 0, `mem_req` high in cycle 1, `mem_ready` high in cycle 1, `done` in cycle 2. That is 2 cycles start-to-done.
- Each extra cycle `mem_ready` stays low adds 1 cycle. There is no timeout.
- While `mem_req` is high, `mem_addr`, `mem_we`, `mem_wstrb` and `mem_wdata` are stable.
- `mem_ready` is ignored outside REQ.
- Inputs are sampled only in IDLE. Changes during REQ or DONE have no effect.
- DONE always returns to IDLE. A new start is accepted only from IDLE, so back-to-back accesses are 3 cycles apart at minimum.
- `rstn` low mid-transaction: the FSM aborts immediately and `mem_req` drops asynchronously. The memory side treats this as a cancelled request.

## Structure
- Package `lsu_pkg` holds:
  - the funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2).
- Sub-module `load_extend` is combinational: inputs `mem_rdata`, `funct3`, `addr[1:0]`; output is the 32-bit extended value. It is shared with the LabH6 debug read path.
- The top level holds the FSM, the request registers and the `rdata` register.

## Test plan
- lw at 0x1000, memory returns 0xDEADBEEF with zero-wait `mem_ready`: `done` at cycle 2, `rdata=0xDEADBEEF`, `stall` high for cycles 0–1 only.
- lb at 0x1003, word 0x80FF7F01: `rdata=0xFFFFFF80`. lbu at the same address gives `0x00000080`.
- sh at 0x2002 with `wdata_in=0x1234ABCD`: `mem_addr=0x2000`, `mem_wstrb=4'b1100`, `mem_wdata=0xABCDABCD`. `mem_ready` delayed 3 cycles gives `done` at cycle 5. `rdata` is unchanged.
- lw at 0x1002: `misalign` pulses, `mem_req` is never asserted, `stall` stays 0, `done` stays 0.
- `rstn` pulled low in REQ during a wait: `mem_req` goes 0 without a clock edge. After release the state is IDLE and a fresh sb to 0x0 completes normally with strobe `4'b0001`.
